// File: rtl/cmd_rx_decoder_if.sv
// ----------------------------------------------------------------------------
// cmd_rx_decoder_if
//   Output stream of the serial command receiver: one decoded 16-bit word per
//   valid/ready handshake.
//
//   Signals
//     out_data   16  decoded word (FIFO head), driven by the receiver
//     out_valid   1  receiver holds at least one word
//     out_ready   1  consumer accepts out_data when out_valid & out_ready
//
//   Modports
//     master  the receiver (drives data/valid, samples ready)
//     slave   the consumer (samples data/valid, drives ready)
// ----------------------------------------------------------------------------
interface cmd_rx_decoder_if;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/cmd_rx_decoder.sv
// ----------------------------------------------------------------------------
// cmd_rx_decoder
//   Receiving end of the serial command link. Bit-aligns to a 16-bit sync
//   pattern, frames the MSB-first bit stream into 16-bit words, discards sync
//   and stuck (all-0 / all-1) words and buffers every other word in a
//   first-word-fall-through FIFO with registered valid/ready outputs.
//
//   Ports
//     cmd_clk     in   1   command clock, one bit per cycle
//     cmd_rst_n   in   1   asynchronous active-low reset
//     cmd_in      in   1   serial bit, MSB first
//     cmd_in_en   in   1   bit qualifier; nothing advances while low
//     out_if      master  decoded word stream (out_data/out_valid/out_ready)
//     locked      out  1   word alignment established
//     overflow    out  1   sticky; a word was dropped on a full FIFO
//     clr_ovf     in   1   one-cycle pulse clearing overflow (a new drop wins)
//
//   Optional feature macro: CMD_RX_STATS_EN
//     Adds sync_words (16) and bad_words (8): saturating counts of sync and
//     stuck words discarded while locked, cleared by reset or clr_ovf.
// ----------------------------------------------------------------------------
module cmd_rx_decoder #(
    parameter logic [15:0] SYNC_PATTERN = 16'h817E,
    parameter int          LOCK_CNT     = 4,   // 1..15
    parameter int          LOSS_CNT     = 2,   // 1..15
    parameter int          FIFO_DEPTH   = 8    // power of two, >= 2
) (
    input  logic              cmd_clk,
    input  logic              cmd_rst_n,
    input  logic              cmd_in,
    input  logic              cmd_in_en,
    cmd_rx_decoder_if.master  out_if,
    output logic              locked,
    output logic              overflow,
    input  logic              clr_ovf
`ifdef CMD_RX_STATS_EN
    ,
    output logic [15:0]       sync_words,
    output logic [7:0]        bad_words
`endif
);

    localparam int         AW         = $clog2(FIFO_DEPTH);
    localparam logic [3:0] LOCK_CNT_W = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_CNT_W = 4'(LOSS_CNT);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_LOCKING,
        ST_LOCKED
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] sr_q, sr_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  sync_cnt_q, sync_cnt_d;
    logic [3:0]  bad_cnt_q, bad_cnt_d;
    logic        boundary, is_sync, is_stuck;
    logic        push, sync_disc, bad_disc;

    // ------------------------------------------------------------------
    // Alignment FSM: decisions are taken on the shift register value that
    // the current bit produces, so a word is classified in the same cycle
    // its last bit arrives.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case statement leaves a latch behind.
        sr_d       = {sr_q[14:0], cmd_in};
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sync_cnt_d = sync_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        push       = 1'b0;
        sync_disc  = 1'b0;
        bad_disc   = 1'b0;
        is_sync    = (sr_d == SYNC_PATTERN);
        is_stuck   = (sr_d == 16'h0000) || (sr_d == 16'hFFFF);
        boundary   = cmd_in_en && (bit_cnt_q == 4'd15);

        if (cmd_in_en) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            unique case (state_q)
                ST_UNLOCKED: begin
                    // Hunt on every bit; a match defines the word boundary.
                    if (is_sync) begin
                        bit_cnt_d  = 4'd0;
                        sync_cnt_d = 4'd1;
                        bad_cnt_d  = 4'd0;
                        state_d    = (LOCK_CNT == 1) ? ST_LOCKED : ST_LOCKING;
                    end
                end
                ST_LOCKING: begin
                    if (boundary) begin
                        if (is_sync) begin
                            sync_cnt_d = sync_cnt_q + 4'd1;
                            if (sync_cnt_d == LOCK_CNT_W) begin
                                state_d   = ST_LOCKED;
                                bad_cnt_d = 4'd0;
                            end
                        end else begin
                            state_d    = ST_UNLOCKED;
                            sync_cnt_d = 4'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Off-boundary sync patterns are ignored: no realignment.
                    if (boundary) begin
                        if (is_sync) begin
                            sync_disc = 1'b1;
                            bad_cnt_d = 4'd0;
                        end else if (is_stuck) begin
                            bad_disc  = 1'b1;
                            bad_cnt_d = bad_cnt_q + 4'd1;
                            if (bad_cnt_d == LOSS_CNT_W) begin
                                state_d    = ST_UNLOCKED;
                                bad_cnt_d  = 4'd0;
                                sync_cnt_d = 4'd0;
                            end
                        end else begin
                            push      = 1'b1;
                            bad_cnt_d = 4'd0;
                        end
                    end
                end
                default: state_d = ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge cmd_clk or negedge cmd_rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!cmd_rst_n) begin
            state_q    <= ST_UNLOCKED;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            sync_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else if (cmd_in_en) begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            sync_cnt_q <= sync_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    assign locked = (state_q == ST_LOCKED);

    // ------------------------------------------------------------------
    // Output FIFO: pointers carry one extra wrap bit; out_data/out_valid
    // are registers loaded with the next head, so a word written into an
    // empty FIFO appears one cycle after its boundary.
    // ------------------------------------------------------------------
    logic [15:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic        full, pop, push_ok, drop;
    logic [15:0] head_d;

    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = out_if.out_valid && out_if.out_ready;
        // A pop on a full FIFO frees the slot being written this cycle.
        push_ok  = push && (!full || pop);
        drop     = push && full && !pop;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        head_d   = (push_ok && (rd_ptr_d == wr_ptr_q)) ? sr_d
                                                       : mem[rd_ptr_d[AW-1:0]];
    end

    // NOTE: the storage array has no reset; out_valid gates every read, so
    // stale contents are never observable and the array maps to plain RAM.
    always_ff @(posedge cmd_clk) begin
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= sr_d;
    end

    always_ff @(posedge cmd_clk or negedge cmd_rst_n) begin
        if (!cmd_rst_n) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            out_if.out_valid <= 1'b0;
            out_if.out_data  <= '0;
            overflow         <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            out_if.out_valid <= (wr_ptr_d != rd_ptr_d);
            out_if.out_data  <= head_d;
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

`ifdef CMD_RX_STATS_EN
    always_ff @(posedge cmd_clk or negedge cmd_rst_n) begin
        if (!cmd_rst_n) begin
            sync_words <= '0;
            bad_words  <= '0;
        end else if (clr_ovf) begin
            sync_words <= '0;
            bad_words  <= '0;
        end else begin
            if (sync_disc && (sync_words != 16'hFFFF)) sync_words <= sync_words + 16'd1;
            if (bad_disc  && (bad_words  != 8'hFF))    bad_words  <= bad_words + 8'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = sync_disc ^ bad_disc;
`endif

endmodule

// File: tb/tb_cmd_rx_decoder.sv
// ----------------------------------------------------------------------------
// tb_cmd_rx_decoder
//   Directed bench for cmd_rx_decoder. Stimulus pushes hand-computed words
//   into exp_q before sending them; a monitor pops and compares every word
//   the DUT hands over. Lock, overflow and reset behaviour are checked
//   inline by the stimulus process.
// ----------------------------------------------------------------------------
module tb_cmd_rx_decoder;

    localparam logic [15:0] SYNC = 16'h817E;

    logic cmd_clk = 1'b0;
    logic cmd_rst_n;
    logic cmd_in;
    logic cmd_in_en;
    logic clr_ovf;
    logic locked;
    logic overflow;
`ifdef CMD_RX_STATS_EN
    logic [15:0] sync_words;
    logic [7:0]  bad_words;
`endif

    cmd_rx_decoder_if bus ();

    cmd_rx_decoder dut (
        .cmd_clk   (cmd_clk),
        .cmd_rst_n (cmd_rst_n),
        .cmd_in    (cmd_in),
        .cmd_in_en (cmd_in_en),
        .out_if    (bus),
        .locked    (locked),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
`ifdef CMD_RX_STATS_EN
        ,
        .sync_words(sync_words),
        .bad_words (bad_words)
`endif
    );

    always #5 cmd_clk = ~cmd_clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at the falling edge completes at the next
    // rising edge, so the head is compared here.
    initial begin
        forever begin
            @(negedge cmd_clk);
            if (cmd_rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got %h expected none", bus.out_data);
                end else begin
                    check("out_data", bus.out_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge cmd_clk);
        #1;
    endtask

    // One qualified bit, optionally preceded by idle cycles carrying junk.
    task automatic send_bit(input logic b, input int gap_max);
        int gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (gap) begin
            cmd_in_en = 1'b0;
            cmd_in    = 1'($urandom);
            tick();
        end
        cmd_in    = b;
        cmd_in_en = 1'b1;
        tick();
        cmd_in_en = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input int gap_max);
        for (int i = 15; i >= 0; i--) send_bit(w[i], gap_max);
    endtask

    task automatic do_reset();
        @(negedge cmd_clk);
        cmd_rst_n = 1'b0;
        exp_q.delete();
        @(negedge cmd_clk);
        cmd_rst_n = 1'b1;
        tick();
    endtask

    // Preamble of three junk bits, four syncs, then one data word.
    task automatic lock_and_send(input logic [15:0] w, input int gap_max, input string tag);
        send_bit(1'b1, gap_max);
        send_bit(1'b0, gap_max);
        send_bit(1'b1, gap_max);
        for (int k = 0; k < 4; k++) begin
            send_word(SYNC, gap_max);
            check($sformatf("%s_locked_sync%0d", tag, k + 1), 16'(locked), 16'(k == 3));
        end
        check({tag, "_valid_before"}, 16'(bus.out_valid), 16'd0);
        exp_q.push_back(w);
        send_word(w, gap_max);
        // Visible right after the edge that shifted in the last bit.
        check({tag, "_valid_latency"}, 16'(bus.out_valid), 16'd1);
        check({tag, "_data_latency"}, bus.out_data, w);
    endtask

    initial begin
        cmd_rst_n     = 1'b0;
        cmd_in        = 1'b0;
        cmd_in_en     = 1'b0;
        clr_ovf       = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        check("rst_data", bus.out_data, 16'h0000);
        check("rst_valid", 16'(bus.out_valid), 16'd0);
        check("rst_locked", 16'(locked), 16'd0);
        check("rst_overflow", 16'(overflow), 16'd0);
        @(negedge cmd_clk);
        cmd_rst_n = 1'b1;
        tick();

        // 1: acquisition and first word.
        lock_and_send(16'hA5C3, 0, "t1");
        repeat (3) tick();

        // 2: fill with the consumer stalled; the ninth word is dropped.
        bus.out_ready = 1'b0;
        for (int w = 1; w <= 9; w++) begin
            if (w <= 8) exp_q.push_back(16'(w));
            send_word(16'(w), 0);
            check($sformatf("t2_overflow_w%0d", w), 16'(overflow), 16'(w == 9));
        end
        check("t2_head_stable", bus.out_data, 16'h0001);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick();
        check("t2_drained", 16'(exp_q.size()), 16'd0);
        tick();
        check("t2_valid_empty", 16'(bus.out_valid), 16'd0);
        check("t2_overflow_sticky", 16'(overflow), 16'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t2_overflow_cleared", 16'(overflow), 16'd0);

        // 3: two stuck words drop lock; four syncs regain it.
        send_word(16'h0000, 0);
        check("t3_locked_after_bad1", 16'(locked), 16'd1);
        send_word(16'h0000, 0);
        check("t3_locked_after_bad2", 16'(locked), 16'd0);
        check("t3_nothing_pushed", 16'(bus.out_valid), 16'd0);
        for (int k = 0; k < 4; k++) begin
            send_word(SYNC, 0);
            check($sformatf("t3_relock_sync%0d", k + 1), 16'(locked), 16'(k == 3));
        end
        exp_q.push_back(16'h1357);
        send_word(16'h1357, 0);
        repeat (3) tick();

        // 4: a data word while locking aborts acquisition.
        do_reset();
        for (int k = 0; k < 3; k++) send_word(SYNC, 0);
        send_word(16'h1234, 0);
        check("t4_unlocked_at_1234", 16'(locked), 16'd0);
        check("t4_1234_not_pushed", 16'(bus.out_valid), 16'd0);
        for (int k = 0; k < 4; k++) begin
            send_word(SYNC, 0);
            check($sformatf("t4_relock_sync%0d", k + 1), 16'(locked), 16'(k == 3));
        end
        exp_q.push_back(16'h5A5A);
        send_word(16'h5A5A, 0);
        repeat (3) tick();

        // 5: idle gaps inside words change nothing; reset mid-word clears all.
        do_reset();
        lock_and_send(16'hA5C3, 3, "t5");
        repeat (3) tick();
        bus.out_ready = 1'b0;
        send_word(16'h1111, 0);
        send_word(16'h2222, 0);
        for (int i = 15; i >= 9; i--) send_bit(SYNC[i], 0);
        check("t5_valid_pre_reset", 16'(bus.out_valid), 16'd1);
        #2;
        cmd_rst_n = 1'b0;
        #1;
        check("t5_rst_data", bus.out_data, 16'h0000);
        check("t5_rst_valid", 16'(bus.out_valid), 16'd0);
        check("t5_rst_locked", 16'(locked), 16'd0);
        check("t5_rst_overflow", 16'(overflow), 16'd0);
        exp_q.delete();
        @(negedge cmd_clk);
        cmd_rst_n     = 1'b1;
        bus.out_ready = 1'b1;
        tick();

`ifdef CMD_RX_STATS_EN
        // 6: statistics count discards only while locked.
        do_reset();
        for (int k = 0; k < 4; k++) send_word(SYNC, 0);
        send_word(SYNC, 0);
        send_word(16'hFFFF, 0);
        exp_q.push_back(16'hBEEF);
        send_word(16'hBEEF, 0);
        check("t6_data", bus.out_data, 16'hBEEF);
        repeat (3) tick();
        check("t6_sync_words", sync_words, 16'd1);
        check("t6_bad_words", 16'(bad_words), 16'd1);
`endif

        check("final_queue_empty", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
